// File: rtl/pwm_guard_pkg.sv
// Shared definitions for the PWM fault guard: FSM encoding and status field widths,
// kept here so the DSP bus register decode can decode STATE/TRIP_CNT the same way.
package pwm_guard_pkg;

  localparam int STATE_W    = 2;
  localparam int TRIP_CNT_W = 8;
  localparam int FILT_CNT_W = 8;
  localparam int HOLD_W     = 16;

  localparam logic [TRIP_CNT_W-1:0] TRIP_CNT_MAX = '1;

  typedef enum logic [STATE_W-1:0] {
    ST_ARMED   = 2'd0,
    ST_TRIPPED = 2'd1,
    ST_REARM   = 2'd2
  } guard_state_e;

endpackage

// File: rtl/fault_filter.sv
// One fault line: 2-FF synchroniser (inverted so 1 = fault) followed by a
// debounce counter that toggles the filtered state after FILT_LEN stable cycles.
module fault_filter
  import pwm_guard_pkg::*;
#(
  parameter int FILT_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic fault_n_raw,
  output logic fault_filt
);

  localparam logic [FILT_CNT_W-1:0] CNT_LAST = FILT_CNT_W'(FILT_LEN - 1);

  logic                  meta_q, meta_d;
  logic                  sync_q, sync_d;
  logic                  filt_q, filt_d;
  logic [FILT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d = ~fault_n_raw;
    sync_d = meta_q;
    filt_d = filt_q;
    cnt_d  = '0;
    // Any cycle where sync agrees with the filtered state restarts the count.
    if (sync_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = ~filt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign fault_filt = filt_q;

endmodule

// File: rtl/pwm_fault_guard.sv
// PWM protection stage: debounced fault lines latch into a sticky register that
// gates every PWM output low; the guard re-arms a fixed hold-off after clearing.
module pwm_fault_guard
  import pwm_guard_pkg::*;
#(
  parameter int N_CH      = 8,
  parameter int FILT_LEN  = 16,
  parameter int REARM_CYC = 200
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [N_CH-1:0]       FAULT_INPUT,
  input  logic [N_CH-1:0]       PWM_IN,
  output logic [N_CH-1:0]       PWM_OUT,
  input  logic [N_CH-1:0]       FAULT_EN,
  input  logic                  CLR_STB,
  input  logic [N_CH-1:0]       CLR_MASK,
  input  logic                  CNT_CLR,
  output logic [N_CH-1:0]       FAULT_FILT,
  output logic [N_CH-1:0]       FAULT_STICKY,
  output logic [STATE_W-1:0]    STATE,
  output logic [TRIP_CNT_W-1:0] TRIP_CNT,
  output logic                  FAULT_XINT
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(REARM_CYC - 1);

  guard_state_e          state_q, state_d;
  logic [N_CH-1:0]       sticky_q, sticky_d;
  logic [N_CH-1:0]       pwm_out_q, pwm_out_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [TRIP_CNT_W-1:0] trip_cnt_q, trip_cnt_d;
  logic                  xint_q, xint_d;
  logic [N_CH-1:0]       flt_set, flt_clr;
  logic                  trip;
  logic                  trip_entry;

  for (genvar i = 0; i < N_CH; i++) begin : g_filt
    fault_filter #(
      .FILT_LEN(FILT_LEN)
    ) u_filt (
      .clk        (CLK),
      .rst        (RESET),
      .fault_n_raw(FAULT_INPUT[i]),
      .fault_filt (FAULT_FILT[i])
    );
  end

  // Clear only applies to lines whose filtered fault has gone away, so set and
  // clear never overlap on the same bit.
  always_comb begin
    flt_set  = FAULT_FILT & FAULT_EN;
    flt_clr  = {N_CH{CLR_STB}} & CLR_MASK & ~FAULT_FILT;
    sticky_d = (sticky_q & ~flt_clr) | flt_set;
    trip     = |sticky_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARMED: begin
        if (trip) state_d = ST_TRIPPED;
      end
      ST_TRIPPED: begin
        if (!trip) state_d = ST_REARM;
      end
      ST_REARM: begin
        if (trip) begin
          state_d = ST_TRIPPED;
        end else if (hold_q == '0) begin
          state_d = ST_ARMED;
        end
      end
      default: state_d = ST_ARMED;
    endcase
  end

  // PWM is gated by the next state so a fault blanks it on the same edge the
  // sticky bit sets.
  always_comb begin
    hold_d = hold_q;
    if (state_q == ST_TRIPPED && state_d == ST_REARM) begin
      hold_d = HOLD_LOAD;
    end else if (state_q == ST_REARM && hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end

    pwm_out_d  = (state_d == ST_ARMED) ? PWM_IN : '0;
    trip_entry = (state_q != ST_TRIPPED) && (state_d == ST_TRIPPED);

    trip_cnt_d = trip_cnt_q;
    if (CNT_CLR) begin
      trip_cnt_d = '0;
    end else if (trip_entry && trip_cnt_q != TRIP_CNT_MAX) begin
      trip_cnt_d = trip_cnt_q + 1'b1;
    end

    xint_d = ~trip;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sticky_q   <= '0;
      pwm_out_q  <= '0;
      hold_q     <= '0;
      trip_cnt_q <= '0;
      xint_q     <= 1'b1;
    end else begin
      sticky_q   <= sticky_d;
      pwm_out_q  <= pwm_out_d;
      hold_q     <= hold_d;
      trip_cnt_q <= trip_cnt_d;
      xint_q     <= xint_d;
    end
  end

  assign PWM_OUT      = pwm_out_q;
  assign FAULT_STICKY = sticky_q;
  assign STATE        = state_q;
  assign TRIP_CNT     = trip_cnt_q;
  assign FAULT_XINT   = xint_q;

endmodule

// File: tb/tb_pwm_fault_guard.sv
// Bench for pwm_fault_guard: table-driven pass-through vectors, hand-written fault
// sequences and a randomized phase, all checked against a cycle reference model.
module tb_pwm_fault_guard;

  localparam int N_CH      = 8;
  localparam int FILT_LEN  = 16;
  localparam int REARM_CYC = 200;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] FAULT_INPUT = 8'hFF;
  logic [7:0] PWM_IN = 8'h00;
  logic [7:0] FAULT_EN = 8'hFF;
  logic       CLR_STB = 1'b0;
  logic [7:0] CLR_MASK = 8'h00;
  logic       CNT_CLR = 1'b0;
  logic [7:0] PWM_OUT;
  logic [7:0] FAULT_FILT;
  logic [7:0] FAULT_STICKY;
  logic [1:0] STATE;
  logic [7:0] TRIP_CNT;
  logic       FAULT_XINT;

  pwm_fault_guard #(
    .N_CH     (N_CH),
    .FILT_LEN (FILT_LEN),
    .REARM_CYC(REARM_CYC)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .FAULT_INPUT (FAULT_INPUT),
    .PWM_IN      (PWM_IN),
    .PWM_OUT     (PWM_OUT),
    .FAULT_EN    (FAULT_EN),
    .CLR_STB     (CLR_STB),
    .CLR_MASK    (CLR_MASK),
    .CNT_CLR     (CNT_CLR),
    .FAULT_FILT  (FAULT_FILT),
    .FAULT_STICKY(FAULT_STICKY),
    .STATE       (STATE),
    .TRIP_CNT    (TRIP_CNT),
    .FAULT_XINT  (FAULT_XINT)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  // Filter: a line flips when the last FILT_LEN synchronised samples all
  // disagree with it; synchronised sample = inverted raw from two edges back.
  logic [7:0] raw_hist[$];
  logic [7:0] m_filt = 8'h00;
  logic [7:0] m_sticky = 8'h00;
  logic [7:0] m_pwm = 8'h00;
  logic [7:0] m_cnt = 8'h00;
  logic       m_xint = 1'b1;
  int         m_mode = 0;       // 0 armed, 1 tripped, 2 rearm
  int         m_elapsed = 0;    // edges spent in rearm without a trip

  always @(posedge CLK) begin : ref_model
    logic [7:0] set_v, clr_v, nxt_v;
    logic       trip_v, entered, all_diff;
    if (RESET) begin
      raw_hist.delete();
      for (int k = 0; k <= FILT_LEN; k++) raw_hist.push_back(8'hFF);
      m_filt = 8'h00; m_sticky = 8'h00; m_pwm = 8'h00; m_cnt = 8'h00;
      m_xint = 1'b1; m_mode = 0; m_elapsed = 0;
    end else begin
      set_v  = m_filt & FAULT_EN;
      clr_v  = CLR_STB ? (CLR_MASK & ~m_filt) : 8'h00;
      nxt_v  = (m_sticky & ~clr_v) | set_v;
      trip_v = (nxt_v != 8'h00);
      for (int i = 0; i < N_CH; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < FILT_LEN; j++)
          if (~raw_hist[raw_hist.size() - 2 - j][i] == m_filt[i]) all_diff = 1'b0;
        if (all_diff) m_filt[i] = ~m_filt[i];
      end
      raw_hist.push_back(FAULT_INPUT);
      void'(raw_hist.pop_front());
      entered = 1'b0;
      case (m_mode)
        0: if (trip_v) begin m_mode = 1; entered = 1'b1; end
        1: if (!trip_v) begin m_mode = 2; m_elapsed = 0; end
        default: begin
          if (trip_v) begin
            m_mode = 1; entered = 1'b1;
          end else begin
            m_elapsed++;
            if (m_elapsed == REARM_CYC) m_mode = 0;
          end
        end
      endcase
      m_pwm = (m_mode == 0) ? PWM_IN : 8'h00;
      if (CNT_CLR) m_cnt = 8'h00;
      else if (entered && m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
      m_xint   = ~trip_v;
      m_sticky = nxt_v;
    end
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mdl_on = 1'b0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, exp);
    end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic tick();
    @(negedge CLK);
    cyc++;
    if (mdl_on) begin
      n_cmp++;
      if (PWM_OUT !== m_pwm || FAULT_FILT !== m_filt || FAULT_STICKY !== m_sticky ||
          STATE !== m_mode[1:0] || TRIP_CNT !== m_cnt || FAULT_XINT !== m_xint) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL model cyc=%0d got pwm=%h filt=%h stk=%h st=%0d cnt=%0d xint=%b want pwm=%h filt=%h stk=%h st=%0d cnt=%0d xint=%b",
                   cyc, PWM_OUT, FAULT_FILT, FAULT_STICKY, STATE, TRIP_CNT, FAULT_XINT,
                   m_pwm, m_filt, m_sticky, m_mode, m_cnt, m_xint);
      end
    end
  endtask

  task automatic clr_pulse(input logic [7:0] mask);
    CLR_MASK = mask;
    CLR_STB  = 1'b1;
    tick();
    CLR_STB  = 1'b0;
  endtask

  task automatic wait_filt(input logic [7:0] exp, output int n);
    n = 0;
    while (FAULT_FILT !== exp && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check8({tag, "_pwm"}, PWM_OUT, 8'h00);
    check8({tag, "_filt"}, FAULT_FILT, 8'h00);
    check8({tag, "_sticky"}, FAULT_STICKY, 8'h00);
    check8({tag, "_state"}, 8'(STATE), 8'd0);
    check8({tag, "_cnt"}, TRIP_CNT, 8'd0);
    check8({tag, "_xint"}, 8'(FAULT_XINT), 8'd1);
  endtask

  typedef struct {
    logic [7:0] pwm_in;
    logic [7:0] exp_pwm_out;
    logic [1:0] exp_state;
    logic       exp_xint;
  } vec_t;

  vec_t tbl[8];

  // ---------------- test sequence ----------------
  initial begin
    int n;
    tbl[0] = '{8'h00, 8'h00, 2'd0, 1'b1};
    tbl[1] = '{8'hFF, 8'hFF, 2'd0, 1'b1};
    tbl[2] = '{8'h55, 8'h55, 2'd0, 1'b1};
    tbl[3] = '{8'hAA, 8'hAA, 2'd0, 1'b1};
    tbl[4] = '{8'h01, 8'h01, 2'd0, 1'b1};
    tbl[5] = '{8'h80, 8'h80, 2'd0, 1'b1};
    tbl[6] = '{8'hC3, 8'hC3, 2'd0, 1'b1};
    tbl[7] = '{8'h3C, 8'h3C, 2'd0, 1'b1};

    RESET = 1'b1;
    tick();
    tick();
    mdl_on = 1'b1;
    check_reset_vals("reset");
    RESET = 1'b0;

    // Idle pass-through, one cycle of latency.
    for (int i = 0; i < 8; i++) begin
      PWM_IN = tbl[i].pwm_in;
      tick();
      check8("pass_pwm", PWM_OUT, tbl[i].exp_pwm_out);
      check8("pass_state", 8'(STATE), 8'(tbl[i].exp_state));
      check8("pass_xint", 8'(FAULT_XINT), 8'(tbl[i].exp_xint));
    end

    // 15-cycle glitch on line 3 is rejected.
    FAULT_INPUT = 8'hF7;
    repeat (15) tick();
    FAULT_INPUT = 8'hFF;
    repeat (20) begin
      tick();
      check8("glitch_filt", FAULT_FILT, 8'h00);
    end
    check8("glitch_state", 8'(STATE), 8'd0);

    // Held fault: filtered on edge 18, everything trips on edge 19.
    PWM_IN = 8'hA5;
    FAULT_INPUT = 8'hF7;
    repeat (17) tick();
    check8("hold_filt17", FAULT_FILT, 8'h00);
    tick();
    check8("hold_filt18", FAULT_FILT, 8'h08);
    check8("hold_pwm18", PWM_OUT, 8'hA5);
    check8("hold_stk18", FAULT_STICKY, 8'h00);
    tick();
    check8("trip_stk", FAULT_STICKY, 8'h08);
    check8("trip_pwm", PWM_OUT, 8'h00);
    check8("trip_xint", 8'(FAULT_XINT), 8'd0);
    check8("trip_state", 8'(STATE), 8'd1);
    check8("trip_cnt", TRIP_CNT, 8'd1);

    // Clear of a still-active fault is ignored.
    clr_pulse(8'h08);
    check8("clr_active_stk", FAULT_STICKY, 8'h08);
    check8("clr_active_state", 8'(STATE), 8'd1);

    FAULT_INPUT = 8'hFF;
    wait_filt(8'h00, n);
    checki("release_lat", n, FILT_LEN + 2);
    clr_pulse(8'h08);
    check8("clr_state", 8'(STATE), 8'd2);
    check8("clr_xint", 8'(FAULT_XINT), 8'd1);
    check8("clr_stk", FAULT_STICKY, 8'h00);
    check8("clr_pwm", PWM_OUT, 8'h00);
    // Count includes the edge that samples CLR_STB.
    n = 1;
    while (PWM_OUT !== 8'hA5 && n < 400) begin
      tick();
      n++;
    end
    checki("rearm_lat", n, REARM_CYC + 1);
    check8("rearm_state", 8'(STATE), 8'd0);

    // Disabled line filters but does not latch.
    FAULT_EN = 8'hF7;
    FAULT_INPUT = 8'hF7;
    repeat (20) tick();
    check8("dis_filt", FAULT_FILT, 8'h08);
    check8("dis_stk", FAULT_STICKY, 8'h00);
    check8("dis_state", 8'(STATE), 8'd0);
    check8("dis_pwm", PWM_OUT, 8'hA5);

    FAULT_INPUT = 8'hF5;
    repeat (19) tick();
    check8("l1_state", 8'(STATE), 8'd1);
    check8("l1_cnt", TRIP_CNT, 8'd2);
    check8("l1_stk", FAULT_STICKY, 8'h02);
    FAULT_INPUT = 8'hF7;
    wait_filt(8'h08, n);
    check8("l1_rel_filt", FAULT_FILT, 8'h08);
    clr_pulse(8'hFF);
    check8("l1_clr_state", 8'(STATE), 8'd2);
    check8("l1_clr_stk", FAULT_STICKY, 8'h00);

    // New fault on line 0 during rearm.
    FAULT_INPUT = 8'hF6;
    repeat (18) tick();
    check8("rearm_hit_st18", 8'(STATE), 8'd2);
    tick();
    check8("rearm_hit_state", 8'(STATE), 8'd1);
    check8("rearm_hit_cnt", TRIP_CNT, 8'd3);
    check8("rearm_hit_stk", FAULT_STICKY, 8'h01);
    FAULT_EN = 8'h00;
    tick();
    check8("en_off_keeps", FAULT_STICKY, 8'h01);

    FAULT_INPUT = 8'hFF;
    FAULT_EN = 8'hFF;
    wait_filt(8'h00, n);
    clr_pulse(8'hFF);
    n = 0;
    while (STATE !== 2'd0 && n < 400) begin
      tick();
      n++;
    end
    check8("back_armed", 8'(STATE), 8'd0);

    // Saturation after 260 more trips.
    for (int t = 0; t < 260; t++) begin
      FAULT_INPUT = 8'hFE;
      repeat (19) tick();
      if (t == 0) check8("sat_first", TRIP_CNT, 8'd4);
      FAULT_INPUT = 8'hFF;
      repeat (19) tick();
      clr_pulse(8'h01);
    end
    check8("sat_cnt", TRIP_CNT, 8'd255);
    check8("sat_state", 8'(STATE), 8'd2);

    // CNT_CLR wins over a simultaneous trip.
    FAULT_INPUT = 8'hFE;
    repeat (18) tick();
    check8("cntclr_pre", 8'(STATE), 8'd2);
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    check8("cntclr_state", 8'(STATE), 8'd1);
    check8("cntclr_cnt", TRIP_CNT, 8'd0);

    // Reset mid-rearm.
    FAULT_INPUT = 8'hFF;
    wait_filt(8'h00, n);
    clr_pulse(8'h01);
    repeat (50) tick();
    check8("mid_rearm_state", 8'(STATE), 8'd2);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check_reset_vals("rst_rearm");

    // Reset mid-filter restarts the synchroniser and debounce.
    FAULT_INPUT = 8'hFE;
    repeat (10) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check8("rst_filt_now", FAULT_FILT, 8'h00);
    repeat (17) tick();
    check8("rst_filt17", FAULT_FILT, 8'h00);
    tick();
    check8("rst_filt18", FAULT_FILT, 8'h01);

    // Randomized phase, model-checked every cycle.
    FAULT_INPUT = 8'hFF;
    repeat (4000) begin
      PWM_IN = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        int l;
        l = int'($urandom_range(0, 7));
        FAULT_INPUT[l] = ($urandom_range(0, 7) != 0);
      end
      if ($urandom_range(0, 99) == 0) FAULT_EN = 8'($urandom) | 8'hF0;
      CLR_STB  = ($urandom_range(0, 7) == 0);
      CLR_MASK = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      CNT_CLR  = ($urandom_range(0, 199) == 0);
      RESET    = ($urandom_range(0, 999) == 0);
      tick();
    end
    RESET = 1'b0;
    CLR_STB = 1'b0;
    CNT_CLR = 1'b0;
    FAULT_INPUT = 8'hFF;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_fault_guard.md
# pwm_fault_guard

Protection stage inserted between the DSP PWM inputs and the gate-driver PWM outputs of the FPGA top level. It synchronises and debounces the eight active-low FAULT_INPUT lines, latches enabled faults into a sticky register, and forces all PWM outputs low on any latched fault. After the DSP clears the faults, it re-arms after a fixed hold-off. It drives the active-low FAULT_XINT interrupt and exposes filtered, sticky and trip-count status for the DSP bus register map.

## Interface
- N_CH, 8, number of fault lines and PWM channels (one fault line per channel index; the widths are independent in use)
- FILT_LEN, 16, number of consecutive stable CLK cycles required before a filtered fault changes state (range 2..255)
- REARM_CYC, 200, number of PWM-off hold cycles after faults clear (1 µs at 200 MHz; range 1..65535)
- CLK  in  1  system clock (200 MHz domain)
- RESET  in  1  synchronous, active-high reset
- FAULT_INPUT  in  N_CH  raw asynchronous fault lines; active-low (0 = fault)
- PWM_IN  in  N_CH  PWM from DSP
- PWM_OUT  out  N_CH  gated, registered PWM to drivers
- FAULT_EN  in  N_CH  per-line enable (1 = fault may latch)
- CLR_STB  in  1  one-cycle clear strobe (DSP write decode)
- CLR_MASK  in  N_CH  sticky bits to clear on CLR_STB
- CNT_CLR  in  1  one-cycle strobe that zeroes TRIP_CNT
- FAULT_FILT  out  N_CH  debounced fault state (1 = fault present)
- FAULT_STICKY  out  N_CH  latched faults
- STATE  out  2  FSM state (ARMED=0, TRIPPED=1, REARM=2)
- TRIP_CNT  out  8  saturating count of ARMED/REARM→TRIPPED transitions
- FAULT_XINT  out  1  active-low interrupt; 0 while any sticky bit is set

## Operation
- Synchroniser: 2-FF per line, inverted, so that sync=1 means fault.
- Filter, per line: 8-bit counter. If sync equals FAULT_FILT, counter=0. Otherwise counter increments. When the counter reaches FILT_LEN-1 while sync still differs, FAULT_FILT toggles and counter=0. Glitches shorter than FILT_LEN cycles are rejected.
- Sticky: set_i = FAULT_FILT[i] & FAULT_EN[i]. Clear_i = CLR_STB & CLR_MASK[i] & ~FAULT_FILT[i]. Set has priority over clear. A clear of a still-active fault is ignored.
- sticky_next is the sticky value after set/clear. trip = |sticky_next.
- FSM states and transitions:
  - ARMED → TRIPPED on trip. PWM passes through.
  - TRIPPED → REARM when trip=0; loads the hold counter with REARM_CYC-1.
  - REARM → TRIPPED on trip. REARM → ARMED when the hold counter reaches 0 with trip=0.
- PWM_OUT: register PWM_IN when the next state is ARMED, else all 0. A fault therefore gates PWM in the same cycle as the sticky bit sets.
- TRIP_CNT: increments on every entry to TRIPPED and saturates at 255. CNT_CLR has priority over increment.
- FAULT_XINT: registered ~trip.
- Disabling FAULT_EN does not clear an existing sticky bit.

## Timing
- Reset values: PWM_OUT=0, FAULT_FILT=0, FAULT_STICKY=0, STATE=ARMED, TRIP_CNT=0, FAULT_XINT=1, all counters=0, sync FFs=0 (= no fault).
- Raw fault edge to FAULT_FILT: 2 (sync) + FILT_LEN cycles.
- FAULT_FILT rise to FAULT_STICKY, PWM_OUT=0, FAULT_XINT=0, STATE=TRIPPED: 1 cycle, all coincident. Raw fault to PWM off: FILT_LEN+3 cycles.
- PWM_IN to PWM_OUT in ARMED: 1 cycle.
- CLR_STB (last fault) to STATE=REARM, FAULT_XINT=1: 1 cycle. The TRIPPED→REARM transition takes 1 cycle, and the hold counter loads REARM_CYC-1 and decrements each REARM cycle. The first passed-through PWM therefore appears REARM_CYC+1 cycles after CLR_STB.
- A RESET assertion at any point, including mid-REARM or mid-filter, returns the block to reset values on the next edge.

## Structure
- Shared package pwm_guard_pkg holds the state encoding (ST_ARMED, ST_TRIPPED, ST_REARM) and the STATE/TRIP_CNT widths, for reuse by the bus register decode.
- Sub-module fault_filter contains one line's synchroniser, counter and filtered output, instantiated N_CH times via generate. The sticky logic, FSM, hold counter and trip counter live in the top of the block.

## Test plan
- Reset then idle with FAULT_INPUT=8'hFF and PWM_IN toggling: PWM_OUT follows with 1-cycle delay, FAULT_XINT=1, STATE=0.
- FAULT_INPUT[3]=0 pulse for 15 cycles (FILT_LEN=16) → FAULT_FILT stays 0, no trip.
- FAULT_INPUT[3]=0 held → FAULT_FILT[3]=1 at cycle 18. On the next cycle: STICKY=8'h08, PWM_OUT=0, FAULT_XINT=0, TRIP_CNT=1.
- CLR_STB with CLR_MASK=8'h08 while the fault is still low → sticky unchanged. Release the fault and wait for FAULT_FILT[3]=0, then clear → REARM. PWM passes again 201 cycles after CLR_STB.
- FAULT_EN=8'hF7 and line 3 faults → FAULT_FILT[3]=1, sticky 0, no trip. A new fault on line 0 during REARM → back to TRIPPED, TRIP_CNT increments.
- 260 trips → TRIP_CNT=255. A simultaneous trip and CNT_CLR → TRIP_CNT=0.
